ifetch_unit: RTL and testbench



---
 rtl/ifetch_unit.sv | 138 +++++++++++++
 tb/tb_ifetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, ready-handshake instruction fetch, next-PC selection and halt.
// Optional performance counters (fetch_count, wait_count) are enabled by defining IFETCH_PERF_CNT_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        advance,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        halted
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] wait_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        imem_req_q, imem_req_d;
  logic        halted_q, halted_d;

  // Jump beats branch; the branch offset is a signed word count relative to pc+4.
  function automatic logic [31:0] next_pc_f(input logic [31:0] cur_pc,
                                            input logic [31:0] cur_instr,
                                            input logic        br,
                                            input logic        jmp,
                                            input logic        zf);
    logic        [31:0] pc4;
    logic signed [31:0] offset;
    pc4    = cur_pc + 32'd4;
    offset = {{14{cur_instr[15]}}, cur_instr[15:0], 2'b00};
    if (jmp)
      return {pc4[31:28], cur_instr[25:0], 2'b00};
    else if (br && zf)
      return pc4 + $unsigned(offset);
    else
      return pc4;
  endfunction

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          pc_d          = next_pc_f(pc_q, instr_q, branch, jump, zero);
          instr_valid_d = 1'b0;
          state_d       = (instr_q[31:26] == OP_HALT) ? HALT : FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    imem_req_d = (state_d == FETCH);
    halted_d   = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      halted_q      <= halted_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] wait_count_q, wait_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    wait_count_d  = wait_count_q;
    if (state_q == FETCH) begin
      if (imem_ready) fetch_count_d = fetch_count_q + 32'd1;
      else            wait_count_d  = wait_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 32'h0;
      wait_count_q  <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
      wait_count_q  <= wait_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign wait_count  = wait_count_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit; three instances with different RESET_PC values share all inputs.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst, imem_ready, advance, branch, jump, zero;
  logic [31:0] imem_rdata;

  logic        req_m, valid_m, halted_m;
  logic [31:0] addr_m, instr_m, pc_m;
  logic [5:0]  op_m;
  logic        req_j, valid_j, halted_j;
  logic [31:0] addr_j, instr_j, pc_j;
  logic [5:0]  op_j;
  logic        req_w, valid_w, halted_w;
  logic [31:0] addr_w, instr_w, pc_w;
  logic [5:0]  op_w;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fc_m, wc_m, fc_j, wc_j, fc_w, wc_w;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(32'h0000_0040)) dut_m (
    .clk(clk), .rst(rst), .imem_req(req_m), .imem_addr(addr_m), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .advance(advance), .branch(branch), .jump(jump), .zero(zero),
    .instr(instr_m), .opcode(op_m), .instr_valid(valid_m), .pc(pc_m), .halted(halted_m)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_count(fc_m), .wait_count(wc_m)
`endif
  );

  ifetch_unit #(.RESET_PC(32'h3000_0000)) dut_j (
    .clk(clk), .rst(rst), .imem_req(req_j), .imem_addr(addr_j), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .advance(advance), .branch(branch), .jump(jump), .zero(zero),
    .instr(instr_j), .opcode(op_j), .instr_valid(valid_j), .pc(pc_j), .halted(halted_j)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_count(fc_j), .wait_count(wc_j)
`endif
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(req_w), .imem_addr(addr_w), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .advance(advance), .branch(branch), .jump(jump), .zero(zero),
    .instr(instr_w), .opcode(op_w), .instr_valid(valid_w), .pc(pc_w), .halted(halted_w)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_count(fc_w), .wait_count(wc_w)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0; advance = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    tick(); tick();
    checks++; if (pc_m !== 32'h40) begin errors++; $display("FAIL reset_pc got %h want %h", pc_m, 32'h40); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_m); end
    checks++; if (req_m !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", req_m); end
    checks++; if (halted_m !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted_m); end
    checks++; if (instr_m !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr_m); end
    rst = 1'b0;
    tick();
    checks++; if (req_m !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", req_m); end
    checks++; if (addr_m !== 32'h40) begin errors++; $display("FAIL first_addr got %h want %h", addr_m, 32'h40); end
    checks++; if (addr_j !== 32'h3000_0000) begin errors++; $display("FAIL first_addr_j got %h want %h", addr_j, 32'h3000_0000); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL first_valid_early got %b want 0", valid_m); end
    tick();
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", valid_m); end
    checks++; if (req_m !== 1'b0) begin errors++; $display("FAIL req_drop got %b want 0", req_m); end
  endtask

  task automatic test_sequential();
    advance = 1'b1;
    tick();
    checks++; if (addr_m !== 32'h44) begin errors++; $display("FAIL seq_addr1 got %h want %h", addr_m, 32'h44); end
    checks++; if (pc_w !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h want 0", pc_w); end
    checks++; if (req_m !== 1'b1 || valid_m !== 1'b0) begin errors++; $display("FAIL seq_fetch got req=%b valid=%b want req=1 valid=0", req_m, valid_m); end
    // advance while fetching must not move the PC
    imem_ready = 1'b0;
    tick();
    checks++; if (pc_m !== 32'h44 || req_m !== 1'b1) begin errors++; $display("FAIL adv_in_fetch got pc=%h req=%b want pc=44 req=1", pc_m, req_m); end
    imem_ready = 1'b1; advance = 1'b0; imem_rdata = 32'h0000_0020;
    tick();
    checks++; if (instr_m !== 32'h0000_0020) begin errors++; $display("FAIL seq_instr got %h want %h", instr_m, 32'h0000_0020); end
    advance = 1'b1;
    tick();
    checks++; if (addr_m !== 32'h48) begin errors++; $display("FAIL seq_addr2 got %h want %h", addr_m, 32'h48); end
    checks++; if (pc_w !== 32'h4) begin errors++; $display("FAIL pc_wrap2 got %h want %h", pc_w, 32'h4); end
    advance = 1'b0; imem_rdata = 32'h0800_0100;
    tick();
  endtask

  task automatic test_jump();
    jump = 1'b1; branch = 1'b1; zero = 1'b1; advance = 1'b1;
    tick();
    checks++; if (pc_j !== 32'h3000_0400) begin errors++; $display("FAIL jump_region got %h want %h", pc_j, 32'h3000_0400); end
    checks++; if (pc_m !== 32'h0000_0400) begin errors++; $display("FAIL jump_over_branch got %h want %h", pc_m, 32'h0000_0400); end
    jump = 1'b0; branch = 1'b0; zero = 1'b0; advance = 1'b0; imem_rdata = 32'h0800_0004;
    tick();
    jump = 1'b1; advance = 1'b1;
    tick();
    checks++; if (pc_m !== 32'h10) begin errors++; $display("FAIL jump_0x10 got %h want %h", pc_m, 32'h10); end
    jump = 1'b0; advance = 1'b0; imem_rdata = 32'h1000_FFFE;
    tick();
  endtask

  task automatic test_branch();
    branch = 1'b1; zero = 1'b1; advance = 1'b1;
    tick();
    checks++; if (pc_m !== 32'h0C) begin errors++; $display("FAIL beq_taken got %h want %h", pc_m, 32'h0C); end
    branch = 1'b0; zero = 1'b0; advance = 1'b0; imem_rdata = 32'h0800_0004;
    tick();
    jump = 1'b1; advance = 1'b1;
    tick();
    jump = 1'b0; advance = 1'b0; imem_rdata = 32'h1000_FFFE;
    tick();
    branch = 1'b1; zero = 1'b0; advance = 1'b1;
    tick();
    checks++; if (pc_m !== 32'h14) begin errors++; $display("FAIL beq_not_taken got %h want %h", pc_m, 32'h14); end
    branch = 1'b0; advance = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    imem_ready = 1'b0;
    tick();
    checks++; if (req_m !== 1'b1 || addr_m !== 32'h14) begin errors++; $display("FAIL pre_rst_fetch got req=%b addr=%h want req=1 addr=14", req_m, addr_m); end
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (pc_m !== 32'h40) begin errors++; $display("FAIL rst_fetch_pc got %h want %h", pc_m, 32'h40); end
    checks++; if (valid_m !== 1'b0 || instr_m !== 32'h0) begin errors++; $display("FAIL rst_fetch_drop got valid=%b instr=%h want valid=0 instr=0", valid_m, instr_m); end
    checks++; if (req_m !== 1'b0) begin errors++; $display("FAIL rst_fetch_req got %b want 0", req_m); end
  endtask

  task automatic test_wait_states();
    imem_ready = 1'b0; imem_rdata = 32'hFC00_0000; rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (req_m !== 1'b1 || addr_m !== 32'h40 || valid_m !== 1'b0) begin
        errors++; $display("FAIL wait_hold[%0d] got req=%b addr=%h valid=%b want 1/40/0", i, req_m, addr_m, valid_m);
      end
    end
`ifdef IFETCH_PERF_CNT_EN
    checks++; if (wc_m !== 32'd3) begin errors++; $display("FAIL wait_count got %0d want 3", wc_m); end
    checks++; if (fc_m !== 32'd0) begin errors++; $display("FAIL fetch_count_pre got %0d want 0", fc_m); end
`endif
    imem_ready = 1'b1;
    tick();
    checks++; if (valid_m !== 1'b1 || op_m !== 6'h3F) begin errors++; $display("FAIL wait_capture got valid=%b op=%h want 1/3f", valid_m, op_m); end
`ifdef IFETCH_PERF_CNT_EN
    checks++; if (fc_m !== 32'd1) begin errors++; $display("FAIL fetch_count got %0d want 1", fc_m); end
    checks++; if (wc_m !== 32'd3) begin errors++; $display("FAIL wait_count_post got %0d want 3", wc_m); end
`endif
  endtask

  task automatic test_halt();
    advance = 1'b1;
    tick();
    checks++; if (halted_m !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", halted_m); end
    checks++; if (pc_m !== 32'h44 || valid_m !== 1'b0) begin errors++; $display("FAIL halt_state got pc=%h valid=%b want 44/0", pc_m, valid_m); end
    for (int i = 0; i < 10; i++) begin
      imem_ready = i[0];
      tick();
      checks++; if (req_m !== 1'b0 || pc_m !== 32'h44 || halted_m !== 1'b1) begin
        errors++; $display("FAIL halt_frozen[%0d] got req=%b pc=%h halted=%b want 0/44/1", i, req_m, pc_m, halted_m);
      end
    end
    checks++; if (instr_m !== 32'hFC00_0000) begin errors++; $display("FAIL halt_instr got %h want %h", instr_m, 32'hFC00_0000); end
  endtask

  task automatic test_reset_in_halt();
    advance = 1'b0; imem_ready = 1'b1; rst = 1'b1;
    tick();
    checks++; if (pc_m !== 32'h40 || halted_m !== 1'b0 || valid_m !== 1'b0) begin
      errors++; $display("FAIL rst_halt got pc=%h halted=%b valid=%b want 40/0/0", pc_m, halted_m, valid_m);
    end
    rst = 1'b0;
    tick();
    checks++; if (req_m !== 1'b1) begin errors++; $display("FAIL restart_req got %b want 1", req_m); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch();
    test_reset_mid_fetch();
    test_wait_states();
    test_halt();
    test_reset_in_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
